// File: rtl/mul_seq_ctrl.sv
// EX-stage sequencer for the iterative multiplier: latches operands, pulses start,
// holds the pipeline until done or timeout, then presents the product for one cycle.
module mul_seq_ctrl #(
  parameter int OP_W    = 16,
  parameter int TIMEOUT = 40,
  parameter int TMR_W   = 6,
  parameter int PERF_W  = 16
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                mul_req,
  input  logic                flush,
  input  logic [OP_W-1:0]     op_a,
  input  logic [OP_W-1:0]     op_b,
  input  logic                mul_done_in,
  input  logic [2*OP_W-1:0]   mul_product_in,
  input  logic                err_clr,
  output logic                mul_start,
  output logic [OP_W-1:0]     mul_a,
  output logic [OP_W-1:0]     mul_b,
  output logic                stall,
  output logic [2*OP_W-1:0]   result,
  output logic                result_valid,
  output logic                timeout_err,
  output logic [PERF_W-1:0]   mul_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             go;

  assign go = mul_req & ~flush;

  // Gated by Reset so the freeze drops the instant reset is applied.
  assign stall = Reset & (((state == IDLE) & go) | (state == RUN));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      timer        <= '0;
      mul_start    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      mul_cnt      <= '0;
    end else begin
      mul_start    <= 1'b0;
      result_valid <= 1'b0;
      // A timeout set further down in the same cycle overrides this clear.
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            mul_a     <= op_a;
            mul_b     <= op_b;
            timer     <= '0;
            mul_start <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          timer <= timer + 1'b1;
          if (flush) begin
            state <= IDLE;
          end else if (mul_done_in && (timer != '0)) begin
            result       <= mul_product_in;
            result_valid <= 1'b1;
            if (mul_cnt != '1) mul_cnt <= mul_cnt + 1'b1;
            state        <= DONE;
          end else if (timer == TMR_LAST) begin
            result       <= '0;
            result_valid <= 1'b1;
            timeout_err  <= 1'b1;
            state        <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: stimulus pushes expected results and stall
// lengths; independent monitors pop and compare when the DUT presents them.
module tb_mul_seq_ctrl;

  localparam int OP_W    = 16;
  localparam int TIMEOUT = 40;

  logic              CLK = 1'b0;
  logic              Reset = 1'b0;
  logic              mul_req = 1'b0, flush = 1'b0, mul_done_in = 1'b0, err_clr = 1'b0;
  logic [OP_W-1:0]   op_a = '0, op_b = '0;
  logic [2*OP_W-1:0] mul_product_in = '0;

  logic              mul_start, stall, result_valid, timeout_err;
  logic [OP_W-1:0]   mul_a, mul_b;
  logic [2*OP_W-1:0] result;
  logic [15:0]       mul_cnt;

  logic              s_start, s_stall, s_valid, s_err;
  logic [OP_W-1:0]   s_a, s_b;
  logic [2*OP_W-1:0] s_result;
  logic [1:0]        s_cnt;

  mul_seq_ctrl #(.OP_W(OP_W), .TIMEOUT(TIMEOUT), .TMR_W(6), .PERF_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .mul_req(mul_req), .flush(flush), .op_a(op_a), .op_b(op_b),
    .mul_done_in(mul_done_in), .mul_product_in(mul_product_in), .err_clr(err_clr),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .stall(stall), .result(result),
    .result_valid(result_valid), .timeout_err(timeout_err), .mul_cnt(mul_cnt)
  );

  mul_seq_ctrl #(.OP_W(OP_W), .TIMEOUT(TIMEOUT), .TMR_W(6), .PERF_W(2)) dut_sat (
    .CLK(CLK), .Reset(Reset), .mul_req(mul_req), .flush(flush), .op_a(op_a), .op_b(op_b),
    .mul_done_in(mul_done_in), .mul_product_in(mul_product_in), .err_clr(err_clr),
    .mul_start(s_start), .mul_a(s_a), .mul_b(s_b), .stall(s_stall), .result(s_result),
    .result_valid(s_valid), .timeout_err(s_err), .mul_cnt(s_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    longint      cnt;
    longint      cnt_sat;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   stall_q[$];
  int   checks = 0, errors = 0;

  // Reference model state
  longint      done_count = 0;
  logic        err_m = 1'b0;
  logic [31:0] last_res = '0;
  int          exp_starts = 0, seen_starts = 0, stall_len = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Result monitor
  always @(negedge CLK) begin
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("mul_cnt", mul_cnt, e.cnt);
        chk("mul_cnt_sat", s_cnt, e.cnt_sat);
        chk("timeout_err", timeout_err, e.err);
      end
    end
  end

  // Stall-run-length and start-pulse monitor
  always @(negedge CLK) begin
    if (mul_start) seen_starts++;
    if (!Reset) begin
      stall_len = 0;
    end else if (stall) begin
      stall_len++;
    end else if (stall_len > 0) begin
      if (stall_q.size() == 0) chk("unexpected_stall_run", stall_len, 0);
      else chk("stall_len", stall_len, stall_q.pop_front());
      stall_len = 0;
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    mul_req = 1'b1;
    op_a    = a;
    op_b    = b;
    exp_starts++;
  endtask

  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input int k,
                        input logic hold, input logic early);
    exp_t e;
    logic [31:0] p;
    issue(a, b);
    done_count++;
    last_res  = 32'(a) * 32'(b);
    e.res     = last_res;
    e.cnt     = sat(done_count, 65535);
    e.cnt_sat = sat(done_count, 3);
    e.err     = err_m;
    exp_q.push_back(e);
    stall_q.push_back(k + 2);
    @(posedge CLK) #1;
    chk("mul_start", mul_start, 1);
    chk("mul_a", mul_a, a);
    chk("mul_b", mul_b, b);
    mul_req        = hold;
    mul_done_in    = early;
    mul_product_in = 32'hDEAD_BEEF;
    for (int i = 1; i <= k; i++) begin
      @(posedge CLK) #1;
      mul_done_in = (i == k);
      p = 32'(mul_a) * 32'(mul_b);
      mul_product_in = (i == k) ? p : 32'h1234_5678;
    end
    @(posedge CLK) #1;
    mul_done_in = 1'b0;
    chk("stall_in_done", stall, 0);
    if (!hold) mul_req = 1'b0;
    @(posedge CLK) #1;
  endtask

  task automatic do_timeout(input logic [15:0] a, input logic [15:0] b, input logic clr);
    exp_t e;
    issue(a, b);
    err_clr   = clr;
    last_res  = '0;
    e.res     = '0;
    e.cnt     = sat(done_count, 65535);
    e.cnt_sat = sat(done_count, 3);
    e.err     = 1'b1;
    exp_q.push_back(e);
    stall_q.push_back(TIMEOUT + 1);
    @(posedge CLK) #1;
    mul_req = 1'b0;
    repeat (TIMEOUT) @(posedge CLK) #1;
    chk("timeout_valid", result_valid, 1);
    chk("timeout_err_set", timeout_err, 1);
    @(posedge CLK) #1;
    err_m   = clr ? 1'b0 : 1'b1;
    err_clr = 1'b0;
  endtask

  task automatic do_flush(input logic [15:0] a, input logic [15:0] b, input int n);
    issue(a, b);
    stall_q.push_back(n + 2);
    @(posedge CLK) #1;
    mul_req = 1'b0;
    repeat (n) @(posedge CLK) #1;
    flush = 1'b1;
    @(posedge CLK) #1;
    flush = 1'b0;
    chk("flush_stall_drop", stall, 0);
    chk("flush_result_kept", result, last_res);
    chk("flush_cnt_kept", mul_cnt, sat(done_count, 65535));
    @(posedge CLK) #1;
  endtask

  initial begin
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_cnt", mul_cnt, 0);
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b1;
    @(posedge CLK) #1;

    do_mul(16'd3, 16'd5, 34, 1'b0, 1'b0);
    chk("single_cnt", mul_cnt, 1);

    do_mul(16'd7, 16'd9, 4, 1'b1, 1'b1);
    do_mul(16'hFFFF, 16'hFFFF, 1, 1'b0, 1'b0);
    chk("b2b_result", result, 32'hFFFE_0001);

    do_flush(16'd11, 16'd13, 10);

    mul_req = 1'b1;
    flush   = 1'b1;
    #1 chk("flush_idle_stall", stall, 0);
    @(posedge CLK) #1;
    chk("flush_idle_nostart", mul_start, 0);
    mul_req = 1'b0;
    flush   = 1'b0;
    @(posedge CLK) #1;

    do_timeout(16'd2, 16'd2, 1'b0);
    err_clr = 1'b1;
    @(posedge CLK) #1;
    err_clr = 1'b0;
    err_m   = 1'b0;
    chk("err_clr", timeout_err, 0);
    do_timeout(16'd4, 16'd4, 1'b1);
    chk("err_after_clr", timeout_err, 0);

    for (int i = 0; i < 24; i++)
      do_mul(16'($urandom), 16'($urandom), $urandom_range(1, 12),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    mul_req = 1'b0;
    @(posedge CLK) #1;

    mul_done_in    = 1'b1;
    mul_product_in = 32'hCAFE_F00D;
    @(posedge CLK) #1;
    mul_done_in = 1'b0;
    @(posedge CLK) #1;
    chk("spurious_cnt", mul_cnt, sat(done_count, 65535));
    chk("spurious_result", result, last_res);
    chk("sat_cnt", s_cnt, 3);

    issue(16'd6, 16'd6);
    @(posedge CLK) #1;
    mul_req = 1'b1;
    repeat (5) @(posedge CLK) #1;
    Reset = 1'b0;
    #1;
    chk("midrun_stall", stall, 0);
    chk("midrun_start", mul_start, 0);
    chk("midrun_result", result, 0);
    chk("midrun_valid", result_valid, 0);
    chk("midrun_err", timeout_err, 0);
    chk("midrun_cnt", mul_cnt, 0);
    mul_req = 1'b0;
    done_count = 0;
    last_res   = '0;
    err_m      = 1'b0;
    @(posedge CLK) #1;
    @(posedge CLK) #1;
    Reset          = 1'b1;
    mul_done_in    = 1'b1;
    mul_product_in = 32'h0000_0024;
    @(posedge CLK) #1;
    mul_done_in = 1'b0;
    repeat (3) @(posedge CLK) #1;
    chk("post_rst_stall", stall, 0);
    chk("post_rst_cnt", mul_cnt, 0);
    chk("post_rst_result", result, 0);

    do_mul(16'd10, 16'd20, 3, 1'b0, 1'b0);
    repeat (2) @(posedge CLK) #1;

    chk("start_pulses", seen_starts, exp_starts);
    chk("pending_results", exp_q.size(), 0);
    chk("pending_stalls", stall_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
